// File: rtl/step_dir_pkg.sv
// Shared definitions for the step/dir tracker, the step generator and their benches.
package step_dir_pkg;

  typedef logic [1:0] step_state_t;

  localparam step_state_t ST_IDLE = 2'd0;
  localparam step_state_t ST_HIGH = 2'd1;
  localparam step_state_t ST_LOW  = 2'd2;

  localparam int unsigned MIN_HIGH_DEFAULT  = 25;
  localparam int unsigned DIR_SETUP_DEFAULT = 10;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop input synchronizer with rise/fall detection on the synchronized copy.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Left unreset so a level held through reset produces no edge afterwards.
  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    r_prev <= r_sync[SYNC_STAGES-1];
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/step_dir_tracker.sv
// Step/dir receiver: tracks signed position, measures step period and flags protocol errors.
module step_dir_tracker
  import step_dir_pkg::*;
#(
  parameter int unsigned POS_WIDTH   = 16,
  parameter int unsigned PER_WIDTH   = 20,
  parameter int unsigned MIN_HIGH    = MIN_HIGH_DEFAULT,
  parameter int unsigned DIR_SETUP   = DIR_SETUP_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_drv_step,
  input  logic                 i_drv_dir,
  input  logic                 i_drv_enable_sm,
  input  logic                 i_pos_clear,
  input  logic                 i_err_clear,
  output logic [POS_WIDTH-1:0] o_position,
  output logic                 o_step_valid,
  output logic [PER_WIDTH-1:0] o_period,
  output logic                 o_period_valid,
  output logic                 o_moving,
  output logic                 o_err_width,
  output logic                 o_err_setup,
  output logic                 o_err_disabled
);

  localparam int unsigned HW = $clog2(MIN_HIGH + 1);
  localparam int unsigned SW = $clog2(DIR_SETUP + 1);
  localparam logic [HW-1:0] HIGH_SAT  = HW'(MIN_HIGH);
  localparam logic [SW-1:0] SETUP_SAT = SW'(DIR_SETUP);

  logic w_step_q, w_step_rise, w_step_fall;
  logic w_dir_q, w_dir_rise, w_dir_fall;
  logic w_en_q, w_en_rise, w_en_fall;
  logic w_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
    .i_clk  (i_clk),
    .i_d    (i_drv_step),
    .o_q    (w_step_q),
    .o_rise (w_step_rise),
    .o_fall (w_step_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dir (
    .i_clk  (i_clk),
    .i_d    (i_drv_dir),
    .o_q    (w_dir_q),
    .o_rise (w_dir_rise),
    .o_fall (w_dir_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .i_clk  (i_clk),
    .i_d    (i_drv_enable_sm),
    .o_q    (w_en_q),
    .o_rise (w_en_rise),
    .o_fall (w_en_fall)
  );

  assign w_unused = ^{w_step_q, w_en_rise, w_en_fall};

  step_state_t          r_state, w_state_d;
  logic [HW-1:0]        r_high_cnt, w_high_cnt_d;
  logic [PER_WIDTH-1:0] r_per_cnt, w_per_cnt_d;
  logic [SW-1:0]        r_setup_cnt, w_setup_cnt_d;
  logic [POS_WIDTH-1:0] w_pos_base, w_pos_d;

  logic w_dir_chg, w_accept, w_ignored, w_per_sat, w_period_ok, w_width_err, w_setup_err;
  logic [SW-1:0] w_setup_eff;

  assign w_dir_chg   = w_dir_rise | w_dir_fall;
  assign w_accept    = w_step_rise & w_en_q;
  assign w_ignored   = w_step_rise & ~w_en_q;
  assign w_per_sat   = &r_per_cnt;
  // A dir change in the very cycle of the step edge counts as zero setup.
  assign w_setup_eff = w_dir_chg ? '0 : r_setup_cnt;
  assign w_setup_err = w_accept & (w_setup_eff < SETUP_SAT);
  assign w_period_ok = w_accept & (r_state != ST_IDLE) & ~w_per_sat;
  assign w_width_err = (r_state == ST_HIGH) & w_step_fall & (r_high_cnt < HIGH_SAT);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_d = ST_HIGH;
      ST_HIGH: begin
        if (w_step_fall)    w_state_d = ST_LOW;
        else if (w_per_sat) w_state_d = ST_IDLE;
      end
      ST_LOW: begin
        if (w_accept)       w_state_d = ST_HIGH;
        else if (w_per_sat) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_high_cnt_d = r_high_cnt;
    if (w_accept) begin
      w_high_cnt_d = HW'(1);
    end else if ((r_state == ST_HIGH) && (r_high_cnt != HIGH_SAT)) begin
      w_high_cnt_d = r_high_cnt + 1'b1;
    end

    w_per_cnt_d = r_per_cnt;
    if (w_accept)        w_per_cnt_d = PER_WIDTH'(1);
    else if (!w_per_sat) w_per_cnt_d = r_per_cnt + 1'b1;

    w_setup_cnt_d = r_setup_cnt;
    if (w_dir_chg)                      w_setup_cnt_d = '0;
    else if (r_setup_cnt != SETUP_SAT)  w_setup_cnt_d = r_setup_cnt + 1'b1;

    // Clear applies before a coincident step is added.
    w_pos_base = i_pos_clear ? '0 : o_position;
    w_pos_d    = w_pos_base;
    if (w_accept) w_pos_d = w_dir_q ? w_pos_base + 1'b1 : w_pos_base - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_high_cnt     <= '0;
      r_per_cnt      <= '0;
      r_setup_cnt    <= SETUP_SAT;
      o_position     <= '0;
      o_step_valid   <= 1'b0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
      o_moving       <= 1'b0;
      o_err_width    <= 1'b0;
      o_err_setup    <= 1'b0;
      o_err_disabled <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_high_cnt     <= w_high_cnt_d;
      r_per_cnt      <= w_per_cnt_d;
      r_setup_cnt    <= w_setup_cnt_d;
      o_position     <= w_pos_d;
      o_step_valid   <= w_accept;
      o_period_valid <= w_period_ok;
      if (w_period_ok) o_period <= r_per_cnt;
      if (w_period_ok)    o_moving <= 1'b1;
      else if (w_per_sat) o_moving <= 1'b0;
      o_err_width    <= w_width_err | (o_err_width & ~i_err_clear);
      o_err_setup    <= w_setup_err | (o_err_setup & ~i_err_clear);
      o_err_disabled <= w_ignored | (o_err_disabled & ~i_err_clear);
    end
  end

endmodule
